// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the controller state encoding and the default data/address widths
// used by regfile_mp and its read-port sub-module.
package regfile_pkg;

    // Controller states: power-up clear sweep, normal operation, and a
    // requested clear sweep.
    typedef enum logic [1:0] {
        INIT_CLR = 2'd0,
        IDLE     = 2'd1,
        CLR      = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file.
// Returns zero when the file is not ready, the port is disabled or the
// address is entry 0; otherwise forwards same-cycle write data (port 1 has
// priority over port 0) ahead of the stored entry.
//
// Ports:
//   ready_i              file is in normal operation
//   rd_en_i, rd_addr_i   this port's enable and address
//   stored_i             storage contents at rd_addr_i
//   we0_i/waddr0_i/wdata0_i, we1_i/waddr1_i/wdata1_i  write ports for bypass
//   rd_data_o            read result
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              ready_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // A nonzero read address implies any matching write address is nonzero,
    // so the bypass never forwards a discarded write to entry 0.
    always_comb begin
        rd_data_o = '0;
        if (ready_i && rd_en_i && (rd_addr_i != '0)) begin
            if (we1_i && (waddr1_i == rd_addr_i)) begin
                rd_data_o = wdata1_i;
            end else if (we0_i && (waddr0_i == rd_addr_i)) begin
                rd_data_o = wdata0_i;
            end else begin
                rd_data_o = stored_i;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports
// with write bypass, and a clear sweep that zeros every entry one per cycle
// after reset and on request.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   we0/waddr0/wdata0        write port 0
//   we1/waddr1/wdata1        write port 1 (wins on same-address collision)
//   rd_en, rd_addr, rd_data  packed read ports, port i at slice i
//   clr_req                  one-cycle request to zero all entries
//   ready                    high only in normal operation
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                sweeping;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT_CLR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            INIT_CLR, CLR: begin
                if (clr_cnt_q == LAST) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = INIT_CLR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Gating with rst keeps data hidden while reset is held even if the
    // state register still says IDLE.
    assign ready    = rst && (state_q == IDLE);
    assign sweeping = (state_q == INIT_CLR) || (state_q == CLR);

    // Single arbitration point for the array. Port 1 is written last so it
    // wins a same-address collision. A write in the cycle clr_req is seen
    // commits here; the sweep that follows zeros it.
    always_ff @(posedge clk) begin
        if (sweeping) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (ready) begin
            if (we0 && (waddr0 != '0)) begin
                mem_q[waddr0] <= wdata0;
            end
            if (we1 && (waddr1 != '0)) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;

        assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
        assign stored = mem_q[addr];

        regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .ready_i   (ready),
            .rd_en_i   (rd_en[gi]),
            .rd_addr_i (addr),
            .stored_i  (stored),
            .we0_i     (we0),
            .waddr0_i  (waddr0),
            .wdata0_i  (wdata0),
            .we1_i     (we1),
            .waddr1_i  (waddr1),
            .wdata1_i  (wdata1),
            .rd_data_o (rd_data[gi*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports we0/we1  input  1 each  write enables, port 0 and port 1.
REQ-007 SHALL have ports waddr0/waddr1  input  ADDR_W each  write addresses.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W each  write data.
REQ-009 SHALL have port rd_en  input  NRD  per-port read enable.
REQ-010 SHALL have port rd_addr  input  NRD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_data  output  NRD*DATA_W  packed read data, port i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port clr_req  input  1  one-cycle request to zero all entries.
REQ-013 SHALL have port ready  output  1  high when the file accepts writes and returns stored data.

Function
REQ-014 SHALL implement FSM states INIT_CLR, IDLE, CLR; after reset the state SHALL be INIT_CLR.
REQ-015 In INIT_CLR and CLR: SHALL write zero to entry clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, then enter IDLE; the sweep SHALL take exactly DEPTH cycles.
REQ-016 ready SHALL be 1 only in IDLE; 0 in INIT_CLR, CLR and during reset.
REQ-017 In IDLE, clr_req=1 SHALL move to CLR with clr_cnt=0 on the next edge; clr_req SHALL be ignored in INIT_CLR/CLR.
REQ-018 In IDLE: weN=1 and waddrN!=0 SHALL write wdataN to entry waddrN at the rising edge; writes to address 0 SHALL be discarded.
REQ-019 Both ports writing the same nonzero address in one cycle: port 1 data SHALL be stored.
REQ-020 In INIT_CLR/CLR, all writes SHALL be discarded.
REQ-021 Reads SHALL be combinational (zero latency); rd_data port i SHALL be 0 when ready=0, rd_en[i]=0, or rd_addr i=0.
REQ-022 Otherwise, bypass: if we1=1 and waddr1 matches, return wdata1; else if we0=1 and waddr0 matches, return wdata0; else return stored entry.
REQ-023 Each read port SHALL index with its own address; no port SHALL alias another port's address.
REQ-024 Entry 0 SHALL read as 0 regardless of storage contents.
REQ-025 clr_req together with a write in the same IDLE cycle: the write SHALL commit, then the sweep SHALL zero it.

Reset
REQ-026 While rst=0 at an edge: state SHALL become INIT_CLR, clr_cnt 0, ready 0; storage array is not reset directly.
REQ-027 rst=0 during INIT_CLR or CLR SHALL restart the sweep from entry 0.
REQ-028 No register content SHALL be observable via rd_data until the INIT_CLR sweep completes.

Structure
REQ-029 State encoding (INIT_CLR/IDLE/CLR) and default DATA_W/ADDR_W constants SHALL live in shared package regfile_pkg.
REQ-030 Per-read-port bypass/mux logic SHALL be a sub-module regfile_rdport, instantiated NRD times via generate.
REQ-031 Storage SHALL be a single DEPTH x DATA_W array with two write ports plus the clear port, arbitrated in one sequential block.

Verification
REQ-032 Release rst, hold idle -> ready=0 for exactly 32 cycles then 1; all reads return 0.
REQ-033 IDLE, we0=1 waddr0=5 wdata0=0xDEADBEEF, rd_addr0=5 rd_en=1 same cycle -> rd_data0=0xDEADBEEF (bypass); next cycle, we0=0 -> still 0xDEADBEEF.
REQ-034 we0 waddr=7 data 0x11, we1 waddr=7 data 0x22 same cycle -> bypass and later read of 7 return 0x22.
REQ-035 we1=1 waddr1=0 data 0xFFFFFFFF -> read of address 0 returns 0 in that cycle and after.
REQ-036 Fill entries 1..31 with index value, pulse clr_req -> ready=0 for 32 cycles, writes during sweep ignored, afterwards all reads 0.
REQ-037 Assert rst=0 at sweep cycle 10 of CLR -> after release, full 32-cycle INIT_CLR sweep, then ready=1.
